coder_seq: RTL and testbench
============================

# coder_seq

Sequential, parametrised successor to the combinational 8-to-3 priority coder. It accepts a W-bit request vector through a valid/ready handshake and emits the index of every set bit, one per handshake, in priority order. The last index of each vector is flagged. It sits between request sources (interrupt lines, arbiter grants, key scanners) and any consumer that needs serialised bit indices.

## Interface
Parameters:
- `W`, 8: request vector width, W ≥ 2.
- `MSB_FIRST`, 0: 0 emits the lowest set bit first; 1 emits the highest set bit first.
- `IW`, `$clog2(W)`: index width (derived; do not override).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  W  request vector.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a vector this cycle.
- `out_idx`  out  IW  index of the current highest-priority pending bit.
- `out_valid`  out  1  `out_idx` valid.
- `out_ready`  in  1  consumer accepts `out_idx`.
- `out_last`  out  1  `out_idx` is the final pending bit of the current vector.
- `zero_err`  out  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- State register: `IDLE`, `DRAIN`. Pending register `pend[W-1:0]`.
- Reset, while `rst`=1 and on the following cycle:
  - state=`IDLE`, `pend`=0, `zero_err`=0.
  - `out_valid`=0, `out_last`=0, `out_idx`=0.
  - `in_valid` is ignored during reset.
- `IDLE`:
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid`=1 and `in_data`≠0: load `pend`=`in_data`, go to `DRAIN`.
  - When `in_valid`=1 and `in_data`=0: the vector is consumed. Stay in `IDLE`. `zero_err`=1 for exactly the next cycle.
- `DRAIN`:
  - `out_valid`=1.
  - `out_idx`=prio_enc(`pend`), selecting the lowest or highest set bit per `MSB_FIRST`.
  - `out_last`=1 iff exactly one bit of `pend` is set, i.e. (`pend` & (`pend`−1))=0.
- Output handshake (`out_valid`&`out_ready`): clear bit `out_idx` of `pend`.
  - If `out_last`=0: remain in `DRAIN`.
  - If `out_last`=1 and no new vector is accepted: go to `IDLE`.
- Back-to-back:
  - `in_ready` = (state=`IDLE`) | (`out_valid`&`out_ready`&`out_last`).
  - A vector accepted in the same cycle as the last output handshake loads directly; the block stays in `DRAIN` with no bubble.
  - A zero vector accepted this way goes to `IDLE` and pulses `zero_err`.
- Backpressure: while `out_ready`=0, `out_idx`, `out_last` and `pend` hold stable. `in_ready`=0 throughout.
- Single-bit vector: first output has `out_last`=1.
- All-ones vector: W outputs; only the W-th has `out_last`=1.
- Reset mid-`DRAIN`: pending bits are discarded. `out_valid`=0 from the next cycle; no partial `out_last` is ever issued.

## Timing
- Input handshake at edge k → `out_valid`=1 in cycle k+1 (1-cycle latency).
- `out_idx`, `out_last` and `out_valid` are combinational from registered `pend`/state only. No input-to-output combinational path exists except `out_ready`→`in_ready`.
- Throughput, with `out_ready` held at 1:
  - A vector with P set bits occupies exactly P output cycles.
  - Consecutive vectors stream with no idle cycles.
- `zero_err` is registered: high in cycle k+1 only.

## Structure
- Shared package `coder_pkg`:
  - mode constants `LSB_FIRST`=0 and `MSB_FIRST`=1;
  - state encoding (`IDLE`=1'b0, `DRAIN`=1'b1);
  - a `clog2`-style index-width function with a minimum result of 1.
- Sub-module `prio_enc` (parameters `W`, `MSB_FIRST`): purely combinational. Maps a W-bit vector to an IW-bit index of the winning set bit, plus an `any` flag. It is the generalised form of the existing 8-to-3 coder and is reused by `coder_seq`.
- `coder_seq` holds the FSM, the `pend` register, last-bit detection and the handshake logic.

## Test plan
All scenarios use W=8.
- Reset with `in_valid`=1 held: `out_valid`=0, `zero_err`=0, `pend` unchanged at 0. First vector is accepted only after `rst` falls.
- `MSB_FIRST`=0, `in_data`=8'b1010_0100, `out_ready`=1:
  - outputs 2, 5, 7 on three consecutive cycles;
  - `out_last` only with 7;
  - first `out_valid` one cycle after the input handshake.
- `MSB_FIRST`=1, same vector: outputs 7, 5, 2; `out_last` with 2.
- Backpressure, `in_data`=8'b0001_0001, `out_ready`=0 for 3 cycles:
  - `out_idx`=0 stable, `in_ready`=0 throughout;
  - then 0 and 4 are emitted, `out_last` with 4.
- Back-to-back stream: 8'h80, 8'h00, 8'h03 offered continuously:
  - outputs 7(last), then `zero_err` pulse, then 0, 1(last);
  - `in_ready` high in each last-handshake cycle.
- Reset mid-drain: `in_data`=8'hFF, assert `rst` after two outputs:
  - `out_valid`=0 the next cycle;
  - the next vector 8'h10 yields only 4 with `out_last`=1.

Source files
------------

// File: rtl/coder_pkg.sv
// rtl/coder_pkg.sv - shared mode constants, FSM encoding and index-width helper for coder_seq
package coder_pkg;

    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Never returns less than 1 so a 1-wide index stays legal for tiny vectors.
    function automatic int idx_width(input int w);
        int r;
        r = 1;
        while ((1 << r) < w) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - combinational W-bit priority encoder, lowest or highest set bit wins
module prio_enc #(
    parameter int W         = 8,
    parameter int MSB_FIRST = coder_pkg::LSB_FIRST,
    parameter int IW        = coder_pkg::idx_width(W)
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan towards the winning end; the last hit overwrites earlier ones.
    always_comb begin
        int j;
        j     = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < W; i++) begin
            j = (MSB_FIRST != 0) ? i : (W - 1 - i);
            if (vec_i[j]) begin
                idx_o = IW'(j);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coder_seq.sv
// rtl/coder_seq.sv - serialises the set-bit indices of each accepted request vector
module coder_seq #(
    parameter int W         = 8,
    parameter int MSB_FIRST = coder_pkg::LSB_FIRST,
    parameter int IW        = coder_pkg::idx_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          zero_err
);

    import coder_pkg::state_e;
    import coder_pkg::IDLE;
    import coder_pkg::DRAIN;

    localparam logic [W-1:0] ONE = W'(1);

    state_e         state_q, state_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           zero_err_q, zero_err_d;
    logic [IW-1:0]  enc_idx;
    logic           enc_any;
    logic           single_bit;
    logic           out_fire;
    logic           in_fire;

    prio_enc #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST),
        .IW        (IW)
    ) u_prio_enc (
        .vec_i (pend_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    assign single_bit = (pend_q & (pend_q - ONE)) == '0;
    assign out_valid  = (state_q == DRAIN);
    assign out_idx    = enc_idx;
    assign out_last   = out_valid & enc_any & single_bit;
    assign zero_err   = zero_err_q;

    // A new vector may replace the final pending bit in the same cycle.
    assign out_fire = out_valid & out_ready;
    assign in_ready = (state_q == IDLE) | (out_fire & out_last);
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        zero_err_d = 1'b0;
        if (out_fire) begin
            pend_d = pend_q & ~(ONE << enc_idx);
            if (out_last) begin
                state_d = IDLE;
            end
        end
        if (in_fire) begin
            if (in_data != '0) begin
                pend_d  = in_data;
                state_d = DRAIN;
            end else begin
                state_d    = IDLE;
                zero_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            zero_err_q <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_coder_seq.sv
// tb/tb_coder_seq.sv - scoreboard bench for coder_seq, LSB-first and MSB-first instances side by side
module tb_coder_seq;

    typedef struct packed {
        logic [2:0] idx_lsb;
        logic [2:0] idx_msb;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_last0, zero_err0;
    logic [2:0] out_idx0;
    logic       in_ready1, out_valid1, out_last1, zero_err1;
    logic [2:0] out_idx1;

    int   errors;
    int   checks;
    exp_t q[$];
    logic pend_zero;
    logic prev_rst;
    logic rand_ready;

    coder_seq #(.W(8), .MSB_FIRST(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .out_idx   (out_idx0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_last  (out_last0),
        .zero_err  (zero_err0)
    );

    coder_seq #(.W(8), .MSB_FIRST(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .out_idx   (out_idx1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_last  (out_last1),
        .zero_err  (zero_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the set bits in ascending order; MSB-first is that list reversed.
    task automatic model_push(input logic [7:0] v);
        int   asc[$];
        exp_t e;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) asc.push_back(b);
        end
        for (int k = 0; k < asc.size(); k++) begin
            e.idx_lsb = 3'(asc[k]);
            e.idx_msb = 3'(asc[asc.size() - 1 - k]);
            e.last    = (k == asc.size() - 1);
            q.push_back(e);
        end
    endtask

    initial begin
        pend_zero = 1'b0;
        prev_rst  = 1'b0;
    end

    always @(negedge clk) begin
        logic exp_rdy;
        chk("zero_err_lsb", zero_err0, pend_zero);
        chk("zero_err_msb", zero_err1, pend_zero);
        if (prev_rst) begin
            chk("post_rst_valid", out_valid0, 0);
            chk("post_rst_last", out_last0, 0);
        end
        chk("out_valid_lsb", out_valid0, q.size() != 0);
        chk("out_valid_msb", out_valid1, q.size() != 0);
        exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1);
        chk("in_ready_lsb", in_ready0, exp_rdy);
        chk("in_ready_msb", in_ready1, exp_rdy);
        if (out_valid0 && q.size() != 0) begin
            chk("idx_lsb", out_idx0, q[0].idx_lsb);
            chk("idx_msb", out_idx1, q[0].idx_msb);
            chk("last_lsb", out_last0, q[0].last);
            chk("last_msb", out_last1, q[0].last);
            if (out_ready && !rst) void'(q.pop_front());
        end
        pend_zero = 1'b0;
        if (!rst && in_valid && in_ready0) begin
            if (in_data == 8'h00) pend_zero = 1'b1;
            else model_push(in_data);
        end
        if (rst) q.delete();
        prev_rst = rst;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_vec(input logic [7:0] v);
        int n;
        bit done;
        in_data  = v;
        in_valid = 1'b1;
        n        = 0;
        done     = 0;
        while (!done) begin
            @(negedge clk);
            if (!rst && in_ready0) begin
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    chk("send_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        bit done;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid0) begin
                done = 1;
            end else begin
                n++;
                if (n > 500) begin
                    chk("drain_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=0 exp=1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hA4;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send_vec(8'hA4);
        wait_drain();

        out_ready = 1'b0;
        send_vec(8'h11);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        send_vec(8'h80);
        send_vec(8'h00);
        send_vec(8'h03);
        wait_drain();

        send_vec(8'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_vec(8'h10);
        wait_drain();

        send_vec(8'h01);
        send_vec(8'hFF);
        wait_drain();

        rand_ready = 1'b1;
        for (int it = 0; it < 300; it++) begin
            logic [7:0] v;
            case ($urandom_range(0, 7))
                0:       v = 8'h00;
                1:       v = 8'h01 << $urandom_range(0, 7);
                2:       v = 8'hFF;
                default: v = 8'($urandom);
            endcase
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_vec(v);
        end
        wait_drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
